alu_cond_unit: RTL

- Consumer end of the ALU FLAGS interface.
- Holds the architectural {NEGATIVE, ZERO, CARRY, OVERFLOW} flags register and tracks flag-setting ALU ops still in flight.
- Answers condition-code queries from the branch/predication logic over a valid/ready handshake.
- Stalls each query until all outstanding flag writebacks have landed, so every answer reflects the latest flags.

---
 rtl/alu_cond_unit_if.sv | 22 ++
 rtl/alu_cond_unit.sv | 77 +++++++
 2 files changed

// File: rtl/alu_cond_unit_if.sv
// alu_cond_unit_if: flags writeback, pending-op and condition query signals of alu_cond_unit.
interface alu_cond_unit_if #(parameter int PW = 2);
  logic          set_issue;
  logic          flags_valid;
  logic [3:0]    flags_in;
  logic          cond_req_valid;
  logic          cond_req_ready;
  logic [3:0]    cond_code;
  logic          cond_rsp_valid;
  logic          cond_rsp_pass;
  logic [3:0]    flags_q;
  logic [PW-1:0] pending_cnt;
  logic          err_sticky;
  modport master (
    output set_issue, flags_valid, flags_in, cond_req_valid, cond_code,
    input  cond_req_ready, cond_rsp_valid, cond_rsp_pass, flags_q, pending_cnt, err_sticky
  );
  modport slave (
    input  set_issue, flags_valid, flags_in, cond_req_valid, cond_code,
    output cond_req_ready, cond_rsp_valid, cond_rsp_pass, flags_q, pending_cnt, err_sticky
  );
endinterface

// File: rtl/alu_cond_unit.sv
// alu_cond_unit: {N,Z,C,V} flags register, in-flight flag-op counter and stalled condition queries.
// Define COND_BYPASS_EN to answer straight from flags_in when the last pending writeback lands.
module alu_cond_unit #(
  parameter int PEND_MAX = 3,
  parameter int PW       = $clog2(PEND_MAX + 1)
) (
  input logic          clk,
  input logic          rst_n,
  alu_cond_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam logic [PW-1:0] MAX = PW'(PEND_MAX);
  state_t        state_q, state_d;
  logic [3:0]    code_q, code_d;
  logic          pass_q, pass_d;
  logic [3:0]    flg_q, flg_d;
  logic [PW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          inc, dec;
  // Odd codes are the inverse of the even code below them.
  function automatic logic eval(input logic [3:0] cc, input logic [3:0] f);
    logic [7:0] t;
    t = {1'b1, ~f[2] & (f[3] == f[0]), f[3] == f[0], f[1] & ~f[2], f[0], f[3], f[1], f[2]};
    return t[cc[3:1]] ^ cc[0];
  endfunction
  assign inc   = bus.set_issue & ~bus.flags_valid;
  assign dec   = bus.flags_valid & ~bus.set_issue;
  assign cnt_d = inc && cnt_q != MAX ? cnt_q + PW'(1) : dec && cnt_q != '0 ? cnt_q - PW'(1) : cnt_q;
  assign err_d = err_q | (inc && cnt_q == MAX) | (dec && cnt_q == '0);
  assign flg_d = bus.flags_valid ? bus.flags_in : flg_q;
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    pass_d  = pass_q;
    case (state_q)
      IDLE: if (bus.cond_req_valid) begin
        code_d  = bus.cond_code;
        state_d = WAIT;
      end
      WAIT: if (cnt_q == '0) begin
        pass_d  = eval(code_q, flg_q);
        state_d = RESP;
      end
`ifdef COND_BYPASS_EN
      else if (cnt_q == PW'(1) && bus.flags_valid && !bus.set_issue) begin
        pass_d  = eval(code_q, bus.flags_in);
        state_d = RESP;
      end
`else
`endif
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      code_q  <= '0;
      pass_q  <= 1'b0;
      flg_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      pass_q  <= pass_d;
      flg_q   <= flg_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  assign bus.cond_req_ready = state_q == IDLE;
  assign bus.cond_rsp_valid = state_q == RESP;
  assign bus.cond_rsp_pass  = pass_q;
  assign bus.flags_q        = flg_q;
  assign bus.pending_cnt    = cnt_q;
  assign bus.err_sticky     = err_q;
endmodule
